// File: rtl/tm_pkt_desc_rd_arb.sv
// tm_pkt_desc_rd_arb
// Shares the single read port of the TM packet-descriptor store among NUM_REQ
// per-port scheduler dequeue engines. Each cycle at most one requester wins a
// round-robin arbitration. Its descriptor is flopped onto rd_pkt_desc_req /
// rd_pkt_desc_in, and its index is queued in an in-order tag FIFO. Each
// returning ack pops the FIFO head and is steered back to that requester.
// The tag FIFO depth (MAX_OUTSTANDING) also caps the number of unacked reads.
//
// Optional build macro: TM_PKT_DESC_ARB_STRICT_PRI_EN
//   defined   : req[0] has strict priority. The others round-robin only while
//               req[0] is low, and a req[0] win leaves the pointer untouched.
//   undefined : plain round-robin over all requesters.
//
// Descriptor types are carried as packed vectors of width SCH_PKT_DESC_NBITS
// (sch_pkt_desc_type) and ENQ_PKT_DESC_NBITS (enq_pkt_desc_type).

module tm_pkt_desc_rd_arb #(
  parameter int NUM_REQ            = 4,
  parameter int REQ_ID_NBITS       = 2,
  parameter int MAX_OUTSTANDING    = 4,
  parameter int SCH_PKT_DESC_NBITS = 16,
  parameter int ENQ_PKT_DESC_NBITS = 32,
  localparam int CNT_NBITS         = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ*SCH_PKT_DESC_NBITS-1:0] req_desc,
  output logic [NUM_REQ-1:0]                    gnt,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [ENQ_PKT_DESC_NBITS-1:0]         rsp_desc,
  output logic                                  rd_pkt_desc_req,
  output logic [SCH_PKT_DESC_NBITS-1:0]         rd_pkt_desc_in,
  input  logic                                  rd_pkt_desc_ack,
  input  logic [ENQ_PKT_DESC_NBITS-1:0]         rd_pkt_desc,
  output logic [CNT_NBITS-1:0]                  outstanding,
  output logic                                  err_underflow
);

  localparam int AW = $clog2(MAX_OUTSTANDING);

  logic [REQ_ID_NBITS-1:0] rr_ptr;
  logic [REQ_ID_NBITS-1:0] tag_mem [MAX_OUTSTANDING];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CNT_NBITS-1:0]    tag_cnt;

  logic                    fifo_empty;
  logic                    pop;
  logic                    issue_ok;
  logic                    rr_vld;
  logic [REQ_ID_NBITS-1:0] rr_idx;
  logic                    win_vld;
  logic [REQ_ID_NBITS-1:0] win_idx;
  logic                    grant;
  logic                    ptr_adv;

  // Requester index examined at round-robin offset off from base.
  function automatic logic [REQ_ID_NBITS-1:0] rr_cand(
    input logic [REQ_ID_NBITS-1:0] base,
    input int                      off
  );
    return REQ_ID_NBITS'((int'(base) + off) % NUM_REQ);
  endfunction

  assign fifo_empty = (tag_cnt == '0);
  assign pop        = rd_pkt_desc_ack && !fifo_empty;

  // An ack in the same cycle frees a slot, which keeps back-to-back issue
  // going at full occupancy. Reset gating keeps gnt low while rstn is low,
  // even if requests are still held.
  assign issue_ok   = rstn &&
                      ((tag_cnt < CNT_NBITS'(MAX_OUTSTANDING)) || rd_pkt_desc_ack);

  // Round-robin search starting at rr_ptr. Strict mode keeps requester 0 out
  // of the rotation, because it is handled separately.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef TM_PKT_DESC_ARB_STRICT_PRI_EN
      if (!rr_vld && (rr_cand(rr_ptr, i) != '0) && req[rr_cand(rr_ptr, i)]) begin
`else
      if (!rr_vld && req[rr_cand(rr_ptr, i)]) begin
`endif
        rr_vld = 1'b1;
        rr_idx = rr_cand(rr_ptr, i);
      end
    end
  end

`ifdef TM_PKT_DESC_ARB_STRICT_PRI_EN
  assign win_vld = req[0] || rr_vld;
  assign win_idx = req[0] ? '0 : rr_idx;
  assign grant   = issue_ok && win_vld;
  assign ptr_adv = grant && !req[0];
`else
  assign win_vld = rr_vld;
  assign win_idx = rr_idx;
  assign grant   = issue_ok && win_vld;
  assign ptr_adv = grant;
`endif

  assign gnt         = grant ? (NUM_REQ'(1) << win_idx) : '0;
  assign rsp_valid   = pop ? (NUM_REQ'(1) << tag_mem[rd_ptr]) : '0;
  assign rsp_desc    = rd_pkt_desc;
  assign outstanding = tag_cnt;

  // Issue stage: flop the winner's descriptor toward the store and rotate
  // the pointer past the winner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr          <= '0;
      rd_pkt_desc_req <= 1'b0;
      rd_pkt_desc_in  <= '0;
    end else begin
      rd_pkt_desc_req <= grant;
      if (grant) begin
        rd_pkt_desc_in <= req_desc[int'(win_idx)*SCH_PKT_DESC_NBITS +: SCH_PKT_DESC_NBITS];
      end
      if (ptr_adv) begin
        rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + REQ_ID_NBITS'(1);
      end
    end
  end

  // Tag storage. Only the pointers need reset, so the entries are left
  // unreset.
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_mem[wr_ptr] <= win_idx;
    end
  end

  // Tag FIFO pointers, occupancy and sticky underflow flag. An ack with
  // nothing queued is dropped rather than decrementing the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tag_cnt       <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (grant) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({grant, pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_NBITS'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_NBITS'(1);
        default: tag_cnt <= tag_cnt;
      endcase
      if (rd_pkt_desc_ack && fifo_empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // The eligibility gate must keep occupancy within the tag FIFO depth.
  a_outstanding_max: assert property (@(posedge clk) disable iff (!rstn)
    tag_cnt <= CNT_NBITS'(MAX_OUTSTANDING));

endmodule

// File: doc/tm_pkt_desc_rd_arb.md
Name: tm_pkt_desc_rd_arb

Overview:
Round-robin arbiter that shares the single read port of the TM packet-descriptor store among NUM_REQ dequeue requesters (per-port schedulers).
- Issues at most one rd_pkt_desc_req per cycle.
- Records the winner in an in-order tag FIFO.
- Steers each returning rd_pkt_desc_ack/rd_pkt_desc back to the requester that issued it.
- Sits between the scheduler dequeue engines and the descriptor store, and caps outstanding reads.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
REQ_ID_NBITS, 2, log2(NUM_REQ).
MAX_OUTSTANDING, 4, maximum issued-but-unacked reads; also the tag FIFO depth (power of 2, >=4).

Ports:
clk  in  1  clock
`RESET_SIG (rstn)  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester read request; level held until granted
req_desc  in  NUM_REQ*`SCH_PKT_DESC_NBITS  packed sch_pkt_desc_type per requester; slice i belongs to req[i]
gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the winning req
rsp_valid  out  NUM_REQ  one-hot response strobe to the issuing requester
rsp_desc  out  `ENQ_PKT_DESC_NBITS  enq_pkt_desc_type broadcast to all requesters; valid with rsp_valid
rd_pkt_desc_req  out  1  read strobe to the descriptor store (registered)
rd_pkt_desc_in  out  sch_pkt_desc_type  read descriptor (registered)
rd_pkt_desc_ack  in  1  read-done strobe from the descriptor store
rd_pkt_desc  in  enq_pkt_desc_type  read data from the descriptor store
outstanding  out  log2(MAX_OUTSTANDING)+1  current count of unacked reads
err_underflow  out  1  sticky: an ack arrived while the tag FIFO was empty

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rd_pkt_desc_req=0, rd_pkt_desc_in=0, outstanding=0, err_underflow=0, RR pointer=0, tag FIFO empty.
- Handshake: requester i holds req[i] and req_desc[i] stable until it sees gnt[i]=1. The grant is taken in that same cycle; the requester may present a new request on the next cycle.
- Eligibility: issue is allowed when (outstanding < MAX_OUTSTANDING) or rd_pkt_desc_ack=1 in the same cycle. When issue is not allowed, gnt=0.
- Arbitration: round-robin starting at index ptr. ptr <= winner+1 (mod NUM_REQ) only on a grant cycle; otherwise ptr holds.
- Issue pipeline: on a grant at cycle t:
  - rd_pkt_desc_req=1 and rd_pkt_desc_in=req_desc[winner] at t+1 (flopped).
  - The winner index is pushed into the tag FIFO at t+1.
- Store latency: rd_pkt_desc_ack returns 3 cycles after rd_pkt_desc_req, i.e. at t+4, in issue order.
- Response: when rd_pkt_desc_ack=1, pop the tag FIFO head h, drive rsp_valid[h]=1 and rsp_desc=rd_pkt_desc combinationally in the same cycle. Total req-to-rsp latency is 4 cycles.
- outstanding: +1 on issue, -1 on ack. Simultaneous issue and ack leave it unchanged. It never exceeds MAX_OUTSTANDING; assert this in sim.
- Ack with an empty tag FIFO: rsp_valid stays 0, outstanding stays 0 (saturates), err_underflow is set and stays set until reset.
- Back-to-back: one grant per cycle is sustainable indefinitely at MAX_OUTSTANDING>=4, because acks free slots at the rate of issues.
- Reset mid-operation: all in-flight tags are discarded. Acks arriving after reset deassertion with no matching issue set err_underflow.
- No other state machine: the only state is ptr, the tag FIFO, and the pipeline flops.

Optional Feature:
TM_PKT_DESC_ARB_STRICT_PRI_EN
- Defined: req[0] has strict priority and is granted whenever it is asserted and eligible. Requesters 1..NUM_REQ-1 round-robin among themselves only when req[0]=0. A req[0] win does not move ptr.
- Undefined: plain round-robin over all NUM_REQ requesters, as described above.

Test Plan:
- Single read: req[2]=1 with idx=0x15 at cycle 0 -> gnt[2] at 0; rd_pkt_desc_req with idx 0x15 at 1; ack at 4 -> rsp_valid=4'b0100 at 4; outstanding 0->1->0.
- All four requesters held high for 8 cycles, ptr=0 -> grant order 0,1,2,3,0,1,2,3; rsp_valid follows the same order 4 cycles later.
- Store ack delayed beyond 3 cycles, continuous req[1] -> exactly 4 grants, then gnt=0 with outstanding=4; one ack -> next grant in the same cycle, outstanding stays 4.
- Spurious ack after reset with no issue -> err_underflow=1 and stays 1; rsp_valid=0; outstanding=0.
- Reset asserted with 3 reads in flight -> all outputs 0 immediately; after release, req[3] -> gnt[3] and normal response at +4.
- STRICT_PRI_EN: req[0] and req[1] held continuously -> every grant goes to 0; drop req[0] -> req[1] is granted the next cycle.
